// File: rtl/dsp_addsub_pipe.sv
// Pipelined SIMD add/subtract/accumulate with a per-lane accumulator and valid/ready handshake.
// Lanes are arithmetically independent; a single enable advances or freezes the whole pipe.
module dsp_addsub_pipe #(
  parameter int unsigned width   = 8,
  parameter int unsigned lanes   = 1,
  parameter int unsigned latency = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               op,
  input  logic [width*lanes-1:0]   a,
  input  logic [width*lanes-1:0]   b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [width*lanes-1:0]   y,
  output logic [lanes-1:0]         carry
);

  localparam int unsigned Wt  = width * lanes;
  localparam int          Lat = int'(latency);

  localparam logic [1:0] OpAdd  = 2'b00;
  localparam logic [1:0] OpSub  = 2'b01;
  localparam logic [1:0] OpAcc  = 2'b10;
  localparam logic [1:0] OpLoad = 2'b11;

  if (!(lanes == 1 || lanes == 2 || lanes == 4)) begin : gen_bad_lanes
    $error("dsp_addsub_pipe: lanes must be 1, 2 or 4");
  end
  if (width < 1 || width * lanes > 48) begin : gen_bad_width
    $error("dsp_addsub_pipe: width must be >= 1 and width*lanes <= 48");
  end
  if (latency < 1 || latency > 3) begin : gen_bad_latency
    $error("dsp_addsub_pipe: latency must be 1..3");
  end

  logic                            en;
  logic                            accept;
  logic [Wt-1:0]                   acc_q, acc_d;
  logic [lanes-1:0][width:0]       r_lane;
  logic [Wt-1:0]                   res_y;
  logic [lanes-1:0]                res_c;

  logic [Lat-1:0]                  vld_q;
  logic [Lat-1:0][Wt-1:0]          y_q;
  logic [Lat-1:0][lanes-1:0]       c_q;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;

  // Each lane works on width+1 bits so the top bit is that lane's carry; nothing crosses lanes.
  always_comb begin
    r_lane = '0;
    res_y  = '0;
    res_c  = '0;
    acc_d  = acc_q;
    for (int i = 0; i < int'(lanes); i++) begin
      unique case (op)
        OpAdd:  r_lane[i] = {1'b0, a[i*width +: width]} + {1'b0, b[i*width +: width]};
        OpSub:  r_lane[i] = {1'b0, a[i*width +: width]} + {1'b0, ~b[i*width +: width]}
                            + {{width{1'b0}}, 1'b1};
        OpAcc:  r_lane[i] = {1'b0, acc_q[i*width +: width]} + {1'b0, a[i*width +: width]};
        OpLoad: r_lane[i] = {1'b0, a[i*width +: width]};
      endcase
      res_y[i*width +: width] = r_lane[i][width-1:0];
      res_c[i]                = r_lane[i][width];
      if (op[1]) acc_d[i*width +: width] = r_lane[i][width-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      vld_q <= '0;
      y_q   <= '0;
      c_q   <= '0;
    end else begin
      if (accept) acc_q <= acc_d;
      if (en) begin
        vld_q[0] <= in_valid;
        if (in_valid) begin
          y_q[0] <= res_y;
          c_q[0] <= res_c;
        end
        for (int s = 1; s < Lat; s++) begin
          vld_q[s] <= vld_q[s-1];
          y_q[s]   <= y_q[s-1];
          c_q[s]   <= c_q[s-1];
        end
      end
    end
  end

  assign out_valid = vld_q[Lat-1];
  assign y         = y_q[Lat-1];
  assign carry     = c_q[Lat-1];

endmodule
